// File: rtl/tcam_pkg.sv
// rtl/tcam_pkg.sv - shared op/state encodings for the TCAM lookup controller
package tcam_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_WR     = 3'd1,
        OP_RD     = 3'd2,
        OP_FLUSH  = 3'd3,
        OP_LOOKUP = 3'd4
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RD_WAIT,
        S_CMP,
        S_CMP_WAIT,
        S_CMP_RD,
        S_CRD_WAIT,
        S_FLUSH,
        S_ERR,
        S_RSP
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_LOOKUP;
    endfunction

    // Illegal ops get a CAM-idle holding state so their response timing matches a write.
    function automatic state_e first_state(input logic [2:0] op);
        case (op)
            OP_NOP:    return S_IDLE;
            OP_WR:     return S_WRITE;
            OP_RD:     return S_READ;
            OP_FLUSH:  return S_FLUSH;
            OP_LOOKUP: return S_CMP;
            default:   return S_ERR;
        endcase
    endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// rtl/tcam_prio_enc.sv - hitline priority encoder, lowest set index wins
module tcam_prio_enc #(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic [WORDS-1:0]  hitline_i,
    output logic              any_o,
    output logic [ADDR_W-1:0] idx_o
);

    always_comb begin
        any_o = |hitline_i;
        idx_o = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (hitline_i[i]) idx_o = ADDR_W'(i);
        end
    end

endmodule

// File: rtl/tcam_lookup_ctrl.sv
// rtl/tcam_lookup_ctrl.sv - command/response TCAM controller driving one CAM macro
module tcam_lookup_ctrl
    import tcam_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 4,
    parameter int WORDS   = 16,
    parameter int BANKS   = 1,
    parameter int FLU_CYC = 1,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [2*ID_W-1:0]   cmd_data,
    input  logic [2*ID_W-1:0]   cmd_mask,
    input  logic                cmd_vbit,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2:0]          rsp_op,
    output logic                rsp_err,
    output logic                rsp_hit,
    output logic [ADDR_W-1:0]   rsp_addr,
    output logic [2*ID_W-1:0]   rsp_data,
    output logic [ID_W-1:0]     rsp_dst,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt,
    input  logic                stat_clr,
    output logic                cam_cs,
    output logic                cam_flush,
    output logic                cam_vbe,
    output logic                cam_dcs,
    output logic                cam_wr,
    output logic                cam_rd,
    output logic                cam_cmp,
    output logic                cam_vbi,
    output logic [2*ID_W-1:0]   cam_di,
    output logic [2*ID_W-1:0]   cam_mskb,
    output logic [ADDR_W-1:0]   cam_a,
    output logic [BANKS-1:0]    cam_cbe,
    input  logic [2*ID_W-1:0]   cam_do,
    input  logic                cam_vbo,
    input  logic                cam_hit,
    input  logic [WORDS-1:0]    cam_hitline
);

    localparam int BITS  = 2 * ID_W;
    localparam int FLU_W = (FLU_CYC > 1) ? $clog2(FLU_CYC) : 1;
    // Lookup compares only the PacketID half of each entry.
    localparam logic [BITS-1:0] LKP_MSKB = {{ID_W{1'b1}}, {ID_W{1'b0}}};

    state_e              state_q;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q, line_q;
    logic [BITS-1:0]     data_q, mask_q;
    logic                vbit_q;
    logic [FLU_W-1:0]    flu_q;
    logic                rsp_valid_q, rsp_err_q, rsp_hit_q;
    logic [2:0]          rsp_op_q;
    logic [ADDR_W-1:0]   rsp_addr_q;
    logic [BITS-1:0]     rsp_data_q;
    logic [ID_W-1:0]     rsp_dst_q;
    logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;
    logic                enc_any;
    logic [ADDR_W-1:0]   enc_idx;
    logic                unused_cam_hit;

    // The summary hit flag is not trusted; the hitline alone decides.
    assign unused_cam_hit = cam_hit;

    tcam_prio_enc #(.WORDS(WORDS), .ADDR_W(ADDR_W)) u_prio_enc (
        .hitline_i (cam_hitline),
        .any_o     (enc_any),
        .idx_o     (enc_idx)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            line_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            vbit_q      <= 1'b0;
            flu_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_op_q    <= '0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_dst_q   <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_op != OP_NOP) begin
                        id_q       <= cmd_id;
                        addr_q     <= cmd_addr;
                        data_q     <= cmd_data;
                        mask_q     <= cmd_mask;
                        vbit_q     <= cmd_vbit;
                        flu_q      <= FLU_W'(FLU_CYC - 1);
                        rsp_op_q   <= cmd_op;
                        rsp_err_q  <= !op_legal(cmd_op);
                        rsp_hit_q  <= 1'b0;
                        rsp_addr_q <= (cmd_op == OP_WR || cmd_op == OP_RD) ? cmd_addr : '0;
                        rsp_data_q <= '0;
                        rsp_dst_q  <= '0;
                        state_q    <= first_state(cmd_op);
                    end
                end
                S_WRITE, S_ERR: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_READ:  state_q <= S_RD_WAIT;
                S_RD_WAIT, S_CRD_WAIT: begin
                    if (state_q == S_RD_WAIT) rsp_hit_q <= cam_vbo;
                    else                      hit_cnt_q <= sat_inc(hit_cnt_q);
                    rsp_data_q  <= cam_do;
                    rsp_dst_q   <= cam_vbo ? cam_do[ID_W-1:0] : '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_CMP:   state_q <= S_CMP_WAIT;
                S_CMP_WAIT: begin
                    line_q <= enc_idx;
                    if (enc_any) begin
                        rsp_hit_q  <= 1'b1;
                        rsp_addr_q <= enc_idx;
                        state_q    <= S_CMP_RD;
                    end else begin
                        miss_cnt_q  <= sat_inc(miss_cnt_q);
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end
                end
                S_CMP_RD: state_q <= S_CRD_WAIT;
                S_FLUSH: begin
                    if (flu_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else begin
                        flu_q <= flu_q - FLU_W'(1);
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (stat_clr) begin
                hit_cnt_q  <= '0;
                miss_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        cam_cs    = 1'b0;
        cam_flush = 1'b0;
        cam_vbe   = 1'b0;
        cam_dcs   = 1'b0;
        cam_wr    = 1'b0;
        cam_rd    = 1'b0;
        cam_cmp   = 1'b0;
        cam_vbi   = 1'b0;
        cam_di    = '0;
        cam_mskb  = '0;
        cam_a     = '0;
        case (state_q)
            S_WRITE: begin
                cam_wr   = 1'b1;
                cam_vbe  = 1'b1;
                cam_dcs  = 1'b1;
                cam_vbi  = vbit_q;
                cam_di   = data_q;
                cam_mskb = mask_q;
                cam_a    = addr_q;
            end
            S_READ, S_CMP_RD: begin
                cam_rd  = 1'b1;
                cam_vbe = 1'b1;
                cam_dcs = 1'b1;
                cam_a   = (state_q == S_READ) ? addr_q : line_q;
            end
            S_CMP: begin
                cam_cmp  = 1'b1;
                cam_di   = {id_q, {ID_W{1'b0}}};
                cam_mskb = LKP_MSKB;
            end
            S_FLUSH: cam_flush = 1'b1;
            default: ;
        endcase
        cam_cs = !(state_q == S_IDLE || state_q == S_RSP || state_q == S_ERR);
    end

    assign cam_cbe   = cam_cs ? '1 : '0;
    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_dst   = rsp_dst_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// tb/tb_tcam_lookup_ctrl.sv - scoreboard bench for tcam_lookup_ctrl with a behavioural CAM
module tb_tcam_lookup_ctrl;

    localparam int ID_W = 4, ADDR_W = 4, WORDS = 16, BANKS = 1, FLU_CYC = 3, CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, cmd_vbit = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_id = '0, cmd_addr = '0;
    logic [7:0] cmd_data = '0, cmd_mask = '0;
    logic rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_hit;
    logic [2:0] rsp_op;
    logic [3:0] rsp_addr, rsp_dst;
    logic [7:0] rsp_data;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;
    logic stat_clr = 1'b0;
    logic cam_cs, cam_flush, cam_vbe, cam_dcs, cam_wr, cam_rd, cam_cmp, cam_vbi;
    logic [7:0] cam_di, cam_mskb;
    logic [3:0] cam_a;
    logic [BANKS-1:0] cam_cbe;
    logic [7:0] cam_do = '0;
    logic cam_vbo = 1'b0;
    logic cam_hit;
    logic [WORDS-1:0] cam_hitline = '0;

    logic [7:0] m_data [WORDS];
    logic [7:0] m_mask [WORDS];
    logic [WORDS-1:0] m_vld = '0;

    typedef struct {
        logic [2:0] op;
        logic       err;
        logic       hit;
        logic [3:0] addr;
        logic [7:0] data;
        logic [3:0] dst;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tcam_lookup_ctrl #(.ID_W(ID_W), .ADDR_W(ADDR_W), .WORDS(WORDS), .BANKS(BANKS),
                       .FLU_CYC(FLU_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_vbit(cmd_vbit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_dst(rsp_dst),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .stat_clr(stat_clr),
        .cam_cs(cam_cs), .cam_flush(cam_flush), .cam_vbe(cam_vbe), .cam_dcs(cam_dcs),
        .cam_wr(cam_wr), .cam_rd(cam_rd), .cam_cmp(cam_cmp), .cam_vbi(cam_vbi),
        .cam_di(cam_di), .cam_mskb(cam_mskb), .cam_a(cam_a), .cam_cbe(cam_cbe),
        .cam_do(cam_do), .cam_vbo(cam_vbo), .cam_hit(cam_hit), .cam_hitline(cam_hitline)
    );

    // Summary hit is tied low so any hit must come from the hitline alone.
    assign cam_hit = 1'b0;

    always @(posedge clk) begin
        if (cam_cs && cam_flush) m_vld <= '0;
        else if (cam_cs && cam_wr && cam_vbe) begin
            m_data[cam_a] <= cam_di;
            m_mask[cam_a] <= cam_mskb;
            m_vld[cam_a]  <= cam_vbi;
        end
        if (cam_cs && cam_rd) begin
            cam_do  <= m_data[cam_a];
            cam_vbo <= m_vld[cam_a];
        end
        if (cam_cs && cam_cmp)
            for (int i = 0; i < WORDS; i++)
                cam_hitline[i] <= m_vld[i] && (((m_data[i] ^ cam_di) & m_mask[i] & cam_mskb) == 8'h00);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_op", rsp_op, e.op);
                check("rsp_err", rsp_err, e.err);
                check("rsp_hit", rsp_hit, e.hit);
                check("rsp_addr", rsp_addr, e.addr);
                check("rsp_data", rsp_data, e.data);
                check("rsp_dst", rsp_dst, e.dst);
            end
        end
    end

    task automatic push(input logic [2:0] op, input logic err, input logic hit,
                        input logic [3:0] addr, input logic [7:0] data, input logic [3:0] dst);
        exp_t e;
        e.op = op; e.err = err; e.hit = hit; e.addr = addr; e.data = data; e.dst = dst;
        exp_q.push_back(e);
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [3:0] id, input logic [3:0] addr,
                        input logic [7:0] data, input logic [7:0] mask, input logic vbit);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("cmd_ready_timeout", 0, 1);
        cmd_op = op; cmd_id = id; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
        cmd_vbit = vbit; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, fl;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cam_cs", cam_cs, 0);
        check("rst_cam_flush", cam_flush, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_rsp_data", rsp_data, 0);
        rst = 1'b0;

        push(3'd1, 0, 0, 4'd3, 8'h00, 4'h0);
        send(3'd1, 4'h0, 4'd3, 8'hA5, 8'hF0, 1'b1);
        check("wr_cam_wr", cam_wr, 1);
        check("wr_cam_di", cam_di, 8'hA5);
        check("wr_cam_mskb", cam_mskb, 8'hF0);
        check("wr_cam_a", cam_a, 3);
        wait_done();

        push(3'd2, 0, 1, 4'd3, 8'hA5, 4'h5);
        send(3'd2, 4'h0, 4'd3, 8'h00, 8'h00, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            step();
            check("rd_latency", rsp_valid, k == 2);
        end
        wait_done();

        push(3'd1, 0, 0, 4'd9, 8'h00, 4'h0);
        send(3'd1, 4'h0, 4'd9, 8'hA3, 8'hF0, 1'b1);
        wait_done();
        push(3'd1, 0, 0, 4'd2, 8'h00, 4'h0);
        send(3'd1, 4'h0, 4'd2, 8'hAC, 8'hF0, 1'b1);
        wait_done();

        push(3'd4, 0, 1, 4'd2, 8'hAC, 4'hC);
        send(3'd4, 4'hA, 4'd0, 8'h00, 8'h00, 1'b0);
        check("lkp_cam_di", cam_di, 8'hA0);
        check("lkp_cam_mskb", cam_mskb, 8'hF0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("lkp_hit_latency", rsp_valid, k == 4);
        end
        wait_done();
        check("hit_cnt_1", hit_cnt, 1);

        push(3'd4, 0, 0, 4'd0, 8'h00, 4'h0);
        send(3'd4, 4'h7, 4'd0, 8'h00, 8'h00, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            step();
            check("lkp_miss_latency", rsp_valid, k == 2);
        end
        wait_done();
        check("miss_cnt_1", miss_cnt, 1);

        rsp_ready = 1'b0;
        push(3'd2, 0, 1, 4'd9, 8'hA3, 4'h3);
        send(3'd2, 4'h0, 4'd9, 8'h00, 8'h00, 1'b0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 8'hA3);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_cmd_ready_after", cmd_ready, 1);
        check("bp_rsp_valid_after", rsp_valid, 0);

        send(3'd0, 4'h0, 4'd0, 8'h00, 8'h00, 1'b0);
        check("nop_cmd_ready", cmd_ready, 1);
        check("nop_rsp_valid", rsp_valid, 0);

        push(3'd3, 0, 0, 4'd0, 8'h00, 4'h0);
        send(3'd3, 4'h0, 4'd0, 8'h00, 8'h00, 1'b0);
        n = 0;
        fl = 0;
        while (!rsp_valid && n < 20) begin
            if (cam_flush) fl++;
            step();
            n++;
        end
        check("flush_cycles", fl, FLU_CYC);
        wait_done();
        push(3'd4, 0, 0, 4'd0, 8'h00, 4'h0);
        send(3'd4, 4'hA, 4'd0, 8'h00, 8'h00, 1'b0);
        wait_done();
        check("miss_cnt_after_flush", miss_cnt, 2);

        push(3'd1, 0, 0, 4'd2, 8'h00, 4'h0);
        send(3'd1, 4'h0, 4'd2, 8'hAC, 8'hF0, 1'b1);
        wait_done();
        send(3'd4, 4'hA, 4'd0, 8'h00, 8'h00, 1'b0);
        step();
        step();
        check("cmprd_cam_rd", cam_rd, 1);
        check("cmprd_cam_a", cam_a, 2);
        rst = 1'b1;
        #1;
        check("abort_cam_cs", cam_cs, 0);
        check("abort_cam_rd", cam_rd, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_hit_cnt", hit_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_rsp", rsp_valid, 0);

        push(3'd7, 1, 0, 4'd0, 8'h00, 4'h0);
        send(3'd7, 4'h0, 4'd5, 8'h11, 8'h22, 1'b1);
        check("ill_cam_cs", cam_cs, 0);
        check("ill_rsp_e0", rsp_valid, 0);
        step();
        check("ill_rsp_e1", rsp_valid, 1);
        wait_done();

        for (int i = 0; i < 8; i++) begin
            push(3'd4, 0, 1, 4'd2, 8'hAC, 4'hC);
            send(3'd4, 4'hA, 4'd0, 8'h00, 8'h00, 1'b0);
            wait_done();
            if (i == 6) check("hit_cnt_reach_max", hit_cnt, 7);
        end
        check("hit_cnt_saturated", hit_cnt, 7);

        stat_clr = 1'b1;
        push(3'd4, 0, 1, 4'd2, 8'hAC, 4'hC);
        send(3'd4, 4'hA, 4'd0, 8'h00, 8'h00, 1'b0);
        wait_done();
        check("clr_hit_cnt", hit_cnt, 0);
        check("clr_miss_cnt", miss_cnt, 0);
        stat_clr = 1'b0;
        push(3'd4, 0, 1, 4'd2, 8'hAC, 4'hC);
        send(3'd4, 4'hA, 4'd0, 8'h00, 8'h00, 1'b0);
        wait_done();
        check("post_clr_hit_cnt", hit_cnt, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
